multi_cycle_control: RTL and testbench

Main control FSM for the multi-cycle CPU datapath. It sequences each instruction through fetch, decode, execute, memory and writeback, and drives the ALU operation code, datapath mux selects, register-file, PC and IR write enables. It waits on the memory handshake and uses the ALU zero flag to resolve branches. It decodes opcode/funct from the instruction register and is the producer of the 3-bit ALU op code that the ALU consumes.

---
 rtl/multi_cycle_control.sv | 210 +++++++++++++++++++++
 tb/tb_multi_cycle_control.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_control.sv
// Main control FSM for the multi-cycle CPU datapath.
// Sequences fetch/decode/execute/memory/writeback and drives datapath controls.
module multi_cycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] io_opcode,
  input  logic [5:0] io_funct,
  input  logic       io_zero,
  input  logic       io_mem_ready,
  output logic [2:0] io_alu_op,
  output logic       io_alu_src_a,
  output logic [2:0] io_alu_src_b,
  output logic [1:0] io_pc_source,
  output logic       io_pc_write,
  output logic       io_ir_write,
  output logic       io_mem_read,
  output logic       io_mem_write,
  output logic       io_i_or_d,
  output logic       io_reg_write,
  output logic       io_reg_dst,
  output logic       io_mem_to_reg,
  output logic       io_trap,
  output logic [3:0] io_state
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_I_EXEC    = 4'd10,
    S_I_WB      = 4'd11,
    S_TRAP      = 4'd12
  } state_t;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_XOR  = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_SRL  = 3'd5;
  localparam logic [2:0] OP_SUB  = 3'd6;
  localparam logic [2:0] OP_SLTU = 3'd7;

  state_t     r_state;
  state_t     w_next;
  logic       w_r_ok;
  logic [2:0] w_r_op;
  logic       w_i_ok;
  logic [2:0] w_i_op;
  logic [2:0] w_i_sb;

  always_comb begin
    w_r_ok = 1'b1;
    w_r_op = OP_AND;
    case (io_funct)
      6'h24:        w_r_op = OP_AND;
      6'h25:        w_r_op = OP_OR;
      6'h20, 6'h21: w_r_op = OP_ADD;
      6'h26:        w_r_op = OP_XOR;
      6'h27:        w_r_op = OP_NOR;
      6'h02:        w_r_op = OP_SRL;
      6'h22, 6'h23: w_r_op = OP_SUB;
      6'h2B:        w_r_op = OP_SLTU;
      default:      w_r_ok = 1'b0;
    endcase
  end

  // Arithmetic immediates sign-extend, logical ones zero-extend.
  always_comb begin
    w_i_ok = 1'b1;
    w_i_op = OP_AND;
    w_i_sb = 3'd2;
    case (io_opcode)
      6'h09: begin w_i_op = OP_ADD;  w_i_sb = 3'd2; end
      6'h0B: begin w_i_op = OP_SLTU; w_i_sb = 3'd2; end
      6'h0C: begin w_i_op = OP_AND;  w_i_sb = 3'd4; end
      6'h0D: begin w_i_op = OP_OR;   w_i_sb = 3'd4; end
      6'h0E: begin w_i_op = OP_XOR;  w_i_sb = 3'd4; end
      default: w_i_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:     if (io_mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        if (io_opcode == 6'h23 || io_opcode == 6'h2B)
          w_next = S_MEM_ADDR;
        else if (io_opcode == 6'h00 && w_r_ok)
          w_next = S_R_EXEC;
        else if (io_opcode == 6'h04 || io_opcode == 6'h05)
          w_next = S_BRANCH;
        else if (io_opcode == 6'h02)
          w_next = S_JUMP;
        else if (w_i_ok)
          w_next = S_I_EXEC;
        else
          w_next = S_TRAP;
      end
      S_MEM_ADDR:
        w_next = (io_opcode == 6'h23) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  if (io_mem_ready) w_next = S_MEM_WB;
      S_MEM_WB:    w_next = S_FETCH;
      S_MEM_WRITE: if (io_mem_ready) w_next = S_FETCH;
      S_R_EXEC:    w_next = S_R_WB;
      S_R_WB:      w_next = S_FETCH;
      S_BRANCH:    w_next = S_FETCH;
      S_JUMP:      w_next = S_FETCH;
      S_I_EXEC:    w_next = S_I_WB;
      S_I_WB:      w_next = S_FETCH;
      default:     w_next = r_state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    io_alu_op     = OP_AND;
    io_alu_src_a  = 1'b0;
    io_alu_src_b  = 3'd0;
    io_pc_source  = 2'd0;
    io_pc_write   = 1'b0;
    io_ir_write   = 1'b0;
    io_mem_read   = 1'b0;
    io_mem_write  = 1'b0;
    io_i_or_d     = 1'b0;
    io_reg_write  = 1'b0;
    io_reg_dst    = 1'b0;
    io_mem_to_reg = 1'b0;
    io_trap       = 1'b0;
    case (r_state)
      S_FETCH: begin
        io_mem_read  = 1'b1;
        io_alu_src_b = 3'd1;
        io_alu_op    = OP_ADD;
        io_ir_write  = io_mem_ready;
        io_pc_write  = io_mem_ready;
      end
      S_DECODE: begin
        io_alu_src_b = 3'd3;
        io_alu_op    = OP_ADD;
      end
      S_MEM_ADDR: begin
        io_alu_src_a = 1'b1;
        io_alu_src_b = 3'd2;
        io_alu_op    = OP_ADD;
      end
      S_MEM_READ: begin
        io_mem_read = 1'b1;
        io_i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        io_reg_write  = 1'b1;
        io_mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        io_mem_write = 1'b1;
        io_i_or_d    = 1'b1;
      end
      S_R_EXEC: begin
        io_alu_src_a = 1'b1;
        io_alu_op    = w_r_op;
      end
      S_R_WB: begin
        io_reg_write = 1'b1;
        io_reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        io_alu_src_a = 1'b1;
        io_alu_op    = OP_SUB;
        io_pc_source = 2'd1;
        io_pc_write  = (io_opcode == 6'h04) ? io_zero : !io_zero;
      end
      S_JUMP: begin
        io_pc_source = 2'd2;
        io_pc_write  = 1'b1;
      end
      S_I_EXEC: begin
        io_alu_src_a = 1'b1;
        io_alu_src_b = w_i_sb;
        io_alu_op    = w_i_op;
      end
      S_I_WB: io_reg_write = 1'b1;
      default: io_trap = 1'b1;
    endcase
    // Reset aborts whatever is in flight.
    if (reset) begin
      io_pc_write  = 1'b0;
      io_ir_write  = 1'b0;
      io_mem_read  = 1'b0;
      io_mem_write = 1'b0;
      io_reg_write = 1'b0;
      io_trap      = 1'b0;
    end
  end

  assign io_state = r_state;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Randomized bench for multi_cycle_control.
// Per-instruction expected traces are compared cycle by cycle.
module tb_multi_cycle_control;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] io_opcode = '0;
  logic [5:0] io_funct = '0;
  logic       io_zero = 1'b0;
  logic       io_mem_ready = 1'b0;
  logic [2:0] io_alu_op;
  logic       io_alu_src_a;
  logic [2:0] io_alu_src_b;
  logic [1:0] io_pc_source;
  logic       io_pc_write, io_ir_write, io_mem_read, io_mem_write;
  logic       io_i_or_d, io_reg_write, io_reg_dst, io_mem_to_reg;
  logic       io_trap;
  logic [3:0] io_state;

  multi_cycle_control dut (
    .clk(clk), .reset(reset),
    .io_opcode(io_opcode), .io_funct(io_funct),
    .io_zero(io_zero), .io_mem_ready(io_mem_ready),
    .io_alu_op(io_alu_op), .io_alu_src_a(io_alu_src_a),
    .io_alu_src_b(io_alu_src_b), .io_pc_source(io_pc_source),
    .io_pc_write(io_pc_write), .io_ir_write(io_ir_write),
    .io_mem_read(io_mem_read), .io_mem_write(io_mem_write),
    .io_i_or_d(io_i_or_d), .io_reg_write(io_reg_write),
    .io_reg_dst(io_reg_dst), .io_mem_to_reg(io_mem_to_reg),
    .io_trap(io_trap), .io_state(io_state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic        rdy;
    logic [3:0]  st;
    logic [17:0] o;
  } rec_t;

  rec_t q[$];

  wire [17:0] w_o = {io_alu_op, io_alu_src_a, io_alu_src_b,
    io_pc_source, io_pc_write, io_ir_write, io_mem_read,
    io_mem_write, io_i_or_d, io_reg_write, io_reg_dst,
    io_mem_to_reg, io_trap};

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h op=%0h fn=%0h t=%0t",
               tag, got, exp, io_opcode, io_funct, $time);
    end
  endtask

  function automatic logic [17:0] pk(
    int alu, int sa, int sb, int ps, int pw, int iw, int mr,
    int mw, int id, int rw, int rd, int m2r, int tr);
    logic [17:0] v;
    v = {alu[2:0], sa[0], sb[2:0], ps[1:0], pw[0], iw[0],
         mr[0], mw[0], id[0], rw[0], rd[0], m2r[0], tr[0]};
    return v;
  endfunction

  function automatic void add(logic rdy, int st, logic [17:0] o);
    rec_t r;
    r.rdy = rdy;
    r.st  = st[3:0];
    r.o   = o;
    q.push_back(r);
  endfunction

  // R-type funct -> ALU op, -1 when unsupported.
  function automatic int ralu(logic [5:0] fn);
    case (fn)
      6'h24: return 0;
      6'h25: return 1;
      6'h20: return 2;
      6'h21: return 2;
      6'h26: return 3;
      6'h27: return 4;
      6'h02: return 5;
      6'h22: return 6;
      6'h23: return 6;
      6'h2B: return 7;
      default: return -1;
    endcase
  endfunction

  function automatic int ialu(logic [5:0] op);
    case (op)
      6'h09: return 2;
      6'h0B: return 7;
      6'h0C: return 0;
      6'h0D: return 1;
      6'h0E: return 3;
      default: return -1;
    endcase
  endfunction

  function automatic int isb(logic [5:0] op);
    return (op == 6'h09 || op == 6'h0B) ? 2 : 4;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void build(logic [5:0] op, logic [5:0] fn,
                                logic z, int fw, int mwt);
    logic lw;
    q.delete();
    for (int i = 0; i <= fw; i++)
      add(i == fw, 0,
          pk(2, 0, 1, 0, int'(i == fw), int'(i == fw),
             1, 0, 0, 0, 0, 0, 0));
    add(rb(), 1, pk(2, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    if (op == 6'h23 || op == 6'h2B) begin
      lw = (op == 6'h23);
      add(rb(), 2, pk(2, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      for (int i = 0; i <= mwt; i++)
        add(i == mwt, lw ? 3 : 5,
            pk(0, 0, 0, 0, 0, 0, int'(lw), int'(!lw),
               1, 0, 0, 0, 0));
      if (lw)
        add(rb(), 4, pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
    end else if (op == 6'h00 && ralu(fn) >= 0) begin
      add(rb(), 6, pk(ralu(fn), 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      add(rb(), 7, pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    end else if (op == 6'h04 || op == 6'h05) begin
      add(rb(), 8, pk(6, 1, 0, 1, int'((op == 6'h04) ? z : !z),
                      0, 0, 0, 0, 0, 0, 0, 0));
    end else if (op == 6'h02) begin
      add(rb(), 9, pk(0, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    end else if (ialu(op) >= 0) begin
      add(rb(), 10, pk(ialu(op), 1, isb(op), 0, 0, 0, 0, 0, 0,
                       0, 0, 0, 0));
      add(rb(), 11, pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    end else begin
      for (int i = 0; i < 10; i++)
        add(rb(), 12, pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    end
  endfunction

  // Entered and left at posedge+1.
  task automatic play(int lim, logic z);
    for (int i = 0; i < q.size() && i < lim; i++) begin
      io_mem_ready = q[i].rdy;
      io_zero = (q[i].st == 4'd8) ? z : rb();
      #1;
      chk("state", 32'(io_state), 32'(q[i].st));
      chk("outs", 32'(w_o), 32'(q[i].o));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(int n);
    reset = 1'b1;
    io_mem_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      #1;
      chk("rst_en", 32'(w_o & 18'h1E9), 32'h0);
      @(posedge clk);
      #1;
    end
    chk("rst_state", 32'(io_state), 32'h0);
    chk("rst_trap", 32'(io_trap), 32'h0);
    reset = 1'b0;
  endtask

  task automatic run(logic [5:0] op, logic [5:0] fn, logic z,
                     int fw, int mwt);
    io_opcode = op;
    io_funct = fn;
    build(op, fn, z, fw, mwt);
    play(1000, z);
    if (q[q.size() - 1].st == 4'd12) do_reset(1);
  endtask

  task automatic abort(logic [5:0] op, logic [5:0] fn,
                       int fw, int mwt, int k);
    io_opcode = op;
    io_funct = fn;
    build(op, fn, 1'b0, fw, mwt);
    play(k, 1'b0);
    do_reset(1);
  endtask

  logic [5:0] ops[11] = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h05,
                          6'h02, 6'h09, 6'h0B, 6'h0C, 6'h0D, 6'h0E};
  logic [5:0] fns[10] = '{6'h24, 6'h25, 6'h20, 6'h21, 6'h26,
                          6'h27, 6'h02, 6'h22, 6'h23, 6'h2B};
  logic [5:0] sweep[7] = '{6'h24, 6'h25, 6'h26, 6'h27,
                           6'h02, 6'h22, 6'h2B};

  initial begin
    logic [5:0] op, fn;
    @(posedge clk);
    #1;
    do_reset(3);
    run(6'h00, 6'h21, 1'b0, 0, 0);
    run(6'h23, 6'h00, 1'b0, 0, 2);
    run(6'h04, 6'h00, 1'b1, 0, 0);
    run(6'h05, 6'h00, 1'b1, 0, 0);
    run(6'h05, 6'h00, 1'b0, 0, 0);
    run(6'h04, 6'h00, 1'b0, 0, 0);
    foreach (sweep[i]) run(6'h00, sweep[i], 1'b0, 0, 0);
    run(6'h0D, 6'h00, 1'b0, 0, 0);
    run(6'h09, 6'h00, 1'b0, 0, 0);
    run(6'h2B, 6'h00, 1'b0, 1, 1);
    run(6'h3F, 6'h00, 1'b0, 0, 0);
    run(6'h00, 6'h3F, 1'b0, 0, 0);
    abort(6'h23, 6'h00, 1, 5, 5);
    abort(6'h2B, 6'h00, 0, 3, 4);
    abort(6'h02, 6'h00, 4, 0, 2);
    run(6'h02, 6'h00, 1'b0, 2, 0);
    for (int n = 0; n < 300; n++) begin
      op = ops[$urandom_range(0, 10)];
      fn = fns[$urandom_range(0, 9)];
      if ($urandom_range(0, 15) == 0) op = 6'($urandom);
      if ($urandom_range(0, 15) == 0) fn = 6'($urandom);
      run(op, fn, rb(), $urandom_range(0, 3), $urandom_range(0, 3));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
